despachador: RTL

Elevator dispatch controller for the 4-floor, 10-button elevator. It consumes the pending-request vector produced by the button register, moves the car floor by floor, and opens the door at each stop. At every stop it emits a one-cycle `atendidos` mask naming the requests it has served, so the top level can clear them. The top level closes the loop as `anterior <= actual & ~atendidos`.

---
 rtl/despachador.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/despachador.sv
// rtl/despachador.sv - dispatch controller for a 4-floor elevator
// Moves the car floor by floor, opens the door at stops, and pulses the served-request mask.
module despachador #(
   parameter int T_VIAJE  = 8,
   parameter int T_PUERTA = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [9:0] i_pendientes,
   output logic [1:0] o_piso,
   output logic       o_subiendo,
   output logic       o_bajando,
   output logic       o_puerta_abierta,
   output logic [9:0] o_atendidos
);

   typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTA} t_estado;

   function automatic logic [9:0] f_mask_piso(input logic [1:0] f);
      case (f)
         2'd0:    return 10'b0001000001;
         2'd1:    return 10'b0010000110;
         2'd2:    return 10'b0100011000;
         default: return 10'b1000100000;
      endcase
   endfunction

   function automatic logic [9:0] f_arriba(input logic [1:0] f);
      logic [9:0] m;
      m = '0;
      for (int k = 0; k < 4; k++)
         if (2'(k) > f) m = m | f_mask_piso(2'(k));
      return m;
   endfunction

   function automatic logic [9:0] f_abajo(input logic [1:0] f);
      logic [9:0] m;
      m = '0;
      for (int k = 0; k < 4; k++)
         if (2'(k) < f) m = m | f_mask_piso(2'(k));
      return m;
   endfunction

   function automatic logic [9:0] f_car(input logic [1:0] f);
      return 10'b0001000000 << f;
   endfunction

   // Hall call of floor f in the given direction; floors 1 and 4 lack one each.
   function automatic logic [9:0] f_llamada(input logic [1:0] f, input logic sube);
      case ({sube, f})
         3'b100:  return 10'b0000000001;
         3'b101:  return 10'b0000000100;
         3'b110:  return 10'b0000010000;
         3'b001:  return 10'b0000000010;
         3'b010:  return 10'b0000001000;
         3'b011:  return 10'b0000100000;
         default: return 10'b0000000000;
      endcase
   endfunction

   t_estado    r_estado, w_estado_sig;
   logic [1:0] r_piso, w_piso_sig;
   logic       r_dir, w_dir_sig;
   logic [7:0] r_cnt, w_cnt_sig;
   logic [9:0] r_atendidos, w_atendidos_sig;

   logic [9:0] w_aqui;
   logic       w_arriba, w_abajo;
   logic       w_sube_mov;
   logic [1:0] w_g;
   logic       w_mas_alla;
   logic [9:0] w_servir;
   logic       w_fin_tramo, w_fin_puerta;

   assign w_aqui       = i_pendientes & f_mask_piso(r_piso);
   assign w_arriba     = |(i_pendientes & f_arriba(r_piso));
   assign w_abajo      = |(i_pendientes & f_abajo(r_piso));
   assign w_sube_mov   = (r_estado == SUBIENDO);
   assign w_g          = w_sube_mov ? r_piso + 2'd1 : r_piso - 2'd1;
   assign w_mas_alla   = |(i_pendientes & (w_sube_mov ? f_arriba(w_g) : f_abajo(w_g)));
   // With nothing beyond, the car reverses here, so every call of this floor is served.
   assign w_servir     = i_pendientes & (f_car(w_g) | f_llamada(w_g, w_sube_mov) |
                                         (w_mas_alla ? 10'd0 : f_mask_piso(w_g)));
   assign w_fin_tramo  = (r_cnt == 8'(T_VIAJE - 1));
   assign w_fin_puerta = (r_cnt == 8'(T_PUERTA - 1));

   always_comb begin
      w_estado_sig    = r_estado;
      w_piso_sig      = r_piso;
      w_dir_sig       = r_dir;
      w_cnt_sig       = r_cnt + 8'd1;
      w_atendidos_sig = '0;
      case (r_estado)
         REPOSO, PUERTA: begin
            if (r_estado == REPOSO || w_fin_puerta) begin
               w_cnt_sig = '0;
               if (|w_aqui) begin
                  w_estado_sig    = PUERTA;
                  w_atendidos_sig = w_aqui;
               end else if (w_arriba && (r_dir || !w_abajo)) begin
                  w_estado_sig = SUBIENDO;
                  w_dir_sig    = 1'b1;
               end else if (w_abajo) begin
                  w_estado_sig = BAJANDO;
                  w_dir_sig    = 1'b0;
               end else begin
                  w_estado_sig = REPOSO;
               end
            end
         end
         default: begin
            if (w_fin_tramo) begin
               w_piso_sig = w_g;
               w_cnt_sig  = '0;
               if (|w_servir) begin
                  w_estado_sig    = PUERTA;
                  w_atendidos_sig = w_servir;
               end else if (!w_mas_alla) begin
                  w_estado_sig = REPOSO;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_estado    <= REPOSO;
         r_piso      <= '0;
         r_dir       <= 1'b1;
         r_cnt       <= '0;
         r_atendidos <= '0;
      end else begin
         r_estado    <= w_estado_sig;
         r_piso      <= w_piso_sig;
         r_dir       <= w_dir_sig;
         r_cnt       <= w_cnt_sig;
         r_atendidos <= w_atendidos_sig;
      end
   end

   assign o_piso           = r_piso;
   assign o_subiendo       = (r_estado == SUBIENDO);
   assign o_bajando        = (r_estado == BAJANDO);
   assign o_puerta_abierta = (r_estado == PUERTA);
   assign o_atendidos      = r_atendidos;

endmodule
